// File: rtl/call_stack_ctrl_pkg.sv
// Shared types for the WebAssembly call/return sequencer: FSM states, sticky trap
// codes and command opcodes.
package call_stack_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALL,
    ST_RD,
    ST_RET,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    TRAP_NONE                 = 4'd0,
    TRAP_STACK_UNDERFLOW      = 4'd3,
    TRAP_CALL_STACK_EXHAUSTED = 4'd6
  } trap_t;

  localparam logic CALL_OP = 1'b0;
  localparam logic RET_OP  = 1'b1;

endpackage

// File: rtl/call_stack_ctrl_if.sv
// Command/result bundle between the decode FSM (master) and the call stack
// controller (slave).
interface call_stack_ctrl_if #(
  parameter int ROM_ADDR   = 8,
  parameter int STACK_ADDR = 8,
  parameter int ARGS_W     = 4
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [ROM_ADDR-1:0]   call_target;
  logic [ROM_ADDR-1:0]   ret_pc;
  logic [STACK_ADDR-1:0] sp;
  logic [ARGS_W-1:0]     num_args;
  logic                  done;
  logic [ROM_ADDR-1:0]   next_pc;
  logic [STACK_ADDR-1:0] frame_sp;

  modport master (
    output cmd_valid, cmd_op, call_target, ret_pc, sp, num_args,
    input  cmd_ready, done, next_pc, frame_sp
  );

  modport slave (
    input  cmd_valid, cmd_op, call_target, ret_pc, sp, num_args,
    output cmd_ready, done, next_pc, frame_sp
  );

endinterface

// File: rtl/call_frame_ram.sv
// Frame storage for the call stack: one write port, one registered read port,
// contents are not reset.
module call_frame_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/call_stack_ctrl.sv
// WebAssembly call/return sequencer: pushes {ret_pc, caller_sp} frames on call and
// restores them on return. Define CALL_STACK_STATS_EN to add the max_depth output.
module call_stack_ctrl
  import call_stack_ctrl_pkg::*;
#(
  parameter int ROM_ADDR   = 8,
  parameter int STACK_ADDR = 8,
  parameter int ARGS_W     = 4,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  call_stack_ctrl_if.slave         bus,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     halt,
  output logic [3:0]               trap
`ifdef CALL_STACK_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   max_depth
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam int FW = ROM_ADDR + STACK_ADDR;

  state_t                state;
  trap_t                 trap_q;
  logic [STACK_ADDR:0]   diff;
  logic                  accept;
  logic                  call_ok;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;
  logic [FW-1:0]         wdata;
  logic [FW-1:0]         rdata;

  // The extra top bit of diff is the borrow, i.e. the callee wants more args than exist
  assign diff    = {1'b0, bus.sp} - (STACK_ADDR + 1)'(bus.num_args);
  assign accept  = bus.cmd_valid & bus.cmd_ready;
  assign call_ok = accept && (bus.cmd_op == CALL_OP) && (depth != DW'(DEPTH)) && !diff[STACK_ADDR];
  assign waddr   = depth[AW-1:0];
  assign raddr   = depth[AW-1:0] - AW'(1);
  assign wdata   = {bus.ret_pc, diff[STACK_ADDR-1:0]};
  assign trap    = trap_q;

  // Top frame is read every cycle, so it is already registered when RD is entered
  call_frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_frames (
    .clk   (clk),
    .we    (call_ok),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      trap_q        <= TRAP_NONE;
      bus.cmd_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.next_pc   <= '0;
      bus.frame_sp  <= '0;
      depth         <= '0;
      halt          <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.cmd_ready <= 1'b0;
            if (bus.cmd_op == CALL_OP) begin
              if (depth == DW'(DEPTH)) begin
                state  <= ST_TRAP;
                trap_q <= TRAP_CALL_STACK_EXHAUSTED;
              end else if (diff[STACK_ADDR]) begin
                state  <= ST_TRAP;
                trap_q <= TRAP_STACK_UNDERFLOW;
              end else begin
                state        <= ST_CALL;
                bus.done     <= 1'b1;
                bus.next_pc  <= bus.call_target;
                bus.frame_sp <= diff[STACK_ADDR-1:0];
                depth        <= depth + DW'(1);
              end
            end else if (depth == '0) begin
              halt <= 1'b1;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_CALL: begin
          state         <= ST_IDLE;
          bus.cmd_ready <= 1'b1;
        end
        ST_RD: begin
          state        <= ST_RET;
          bus.done     <= 1'b1;
          bus.next_pc  <= rdata[FW-1:STACK_ADDR];
          bus.frame_sp <= rdata[STACK_ADDR-1:0];
          depth        <= depth - DW'(1);
        end
        ST_RET: begin
          state         <= ST_IDLE;
          bus.cmd_ready <= 1'b1;
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CALL_STACK_STATS_EN
  // High-water mark follows depth on the same edge a push lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_depth <= '0;
    end else if (call_ok && ((depth + DW'(1)) > max_depth)) begin
      max_depth <= depth + DW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed vector table, hand-written
// trap/halt/reset sequences, and random commands against a queue-based frame model.
module tb_call_stack_ctrl;
  import call_stack_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] depth;
  logic          halt;
  logic [3:0]    trap;
`ifdef CALL_STACK_STATS_EN
  logic [DW-1:0] max_depth;
  int            modelMax;
`endif

  always #5 clk = ~clk;

  call_stack_ctrl_if bus ();

  call_stack_ctrl #(
    .ROM_ADDR   (8),
    .STACK_ADDR (8),
    .ARGS_W     (4),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .depth     (depth),
    .halt      (halt),
    .trap      (trap)
`ifdef CALL_STACK_STATS_EN
    ,
    .max_depth (max_depth)
`endif
  );

  typedef struct {
    logic       op;
    logic [7:0] tgt;
    logic [7:0] rpc;
    logic [7:0] spv;
    logic [3:0] args;
    int         expReady;
    int         expDone;
    int         expLat;
    int         expPc;
    int         expFsp;
    int         expDepth;
    int         expTrap;
    int         expHalt;
  } vec_t;

  int nChecks = 0;
  int nFail   = 0;
  int obsReady, obsDone, obsLat, obsPc, obsFsp;

  // Model of live frames, newest at the back
  logic [7:0] qPc[$];
  logic [7:0] qSp[$];

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyReset(input bit checkIt);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (checkIt) begin
      check("rst.ready", int'(bus.cmd_ready), 1);
      check("rst.done", int'(bus.done), 0);
      check("rst.next_pc", int'(bus.next_pc), 0);
      check("rst.frame_sp", int'(bus.frame_sp), 0);
      check("rst.depth", int'(depth), 0);
      check("rst.halt", int'(halt), 0);
      check("rst.trap", int'(trap), 0);
`ifdef CALL_STACK_STATS_EN
      check("rst.max_depth", int'(max_depth), 0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    qPc.delete();
    qSp.delete();
`ifdef CALL_STACK_STATS_EN
    modelMax = 0;
`endif
  endtask

  // Offers one command for one cycle and watches a bounded window for done pulses
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    obsReady        = int'(bus.cmd_ready);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = v.op;
    bus.call_target = v.tgt;
    bus.ret_pc      = v.rpc;
    bus.sp          = v.spv;
    bus.num_args    = v.args;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    obsDone = 0;
    obsLat  = 0;
    obsPc   = -1;
    obsFsp  = -1;
    for (int c = 1; c <= 4; c++) begin
      if (bus.done === 1'b1) begin
        obsDone++;
        if (obsLat == 0) begin
          obsLat = c;
          obsPc  = int'(bus.next_pc);
          obsFsp = int'(bus.frame_sp);
        end
      end
      if (c < 4) @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check({tag, ".ready_before"}, obsReady, v.expReady);
    check({tag, ".done_pulses"}, obsDone, v.expDone);
    if (v.expDone != 0) begin
      check({tag, ".latency"}, obsLat, v.expLat);
      check({tag, ".next_pc"}, obsPc, v.expPc);
      check({tag, ".frame_sp"}, obsFsp, v.expFsp);
    end
    check({tag, ".depth"}, int'(depth), v.expDepth);
    check({tag, ".trap"}, int'(trap), v.expTrap);
    check({tag, ".halt"}, int'(halt), v.expHalt);
    check({tag, ".ready_after"}, int'(bus.cmd_ready), (v.expTrap == 0 && v.expHalt == 0) ? 1 : 0);
`ifdef CALL_STACK_STATS_EN
    check({tag, ".max_depth"}, int'(max_depth), modelMax);
`endif
  endtask

  // Reference: expected outcome of a command derived from the frame queue
  task automatic modelCommand(inout vec_t v);
    v.expReady = 1;
    v.expDone  = 0;
    v.expLat   = 0;
    v.expPc    = 0;
    v.expFsp   = 0;
    v.expTrap  = 0;
    v.expHalt  = 0;
    if (v.op == CALL_OP) begin
      if (qPc.size() == DEPTH) begin
        v.expTrap = 6;
      end else if (int'(v.args) > int'(v.spv)) begin
        v.expTrap = 3;
      end else begin
        qPc.push_back(v.rpc);
        qSp.push_back(8'(int'(v.spv) - int'(v.args)));
        v.expDone = 1;
        v.expLat  = 1;
        v.expPc   = int'(v.tgt);
        v.expFsp  = int'(v.spv) - int'(v.args);
      end
    end else begin
      if (qPc.size() == 0) begin
        v.expHalt = 1;
      end else begin
        v.expDone = 1;
        v.expLat  = 2;
        v.expPc   = int'(qPc.pop_back());
        v.expFsp  = int'(qSp.pop_back());
      end
    end
    v.expDepth = qPc.size();
`ifdef CALL_STACK_STATS_EN
    if (qPc.size() > modelMax) modelMax = qPc.size();
`endif
  endtask

  initial begin
    vec_t v;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = CALL_OP;
    bus.call_target = '0;
    bus.ret_pc      = '0;
    bus.sp          = '0;
    bus.num_args    = '0;

    //            op       tgt  rpc  sp   args rdy done lat pc  fsp dep trp hlt
    tbl[0] = '{CALL_OP, 8'd5,  8'd2, 8'd4,  4'd1,  1, 1, 1, 5,  3,  1, 0, 0};
    tbl[1] = '{RET_OP,  8'd0,  8'd0, 8'd0,  4'd0,  1, 1, 2, 2,  3,  0, 0, 0};
    tbl[2] = '{CALL_OP, 8'd10, 8'd1, 8'd20, 4'd2,  1, 1, 1, 10, 18, 1, 0, 0};
    tbl[3] = '{CALL_OP, 8'd11, 8'd2, 8'd18, 4'd3,  1, 1, 1, 11, 15, 2, 0, 0};
    tbl[4] = '{CALL_OP, 8'd12, 8'd3, 8'd15, 4'd15, 1, 1, 1, 12, 0,  3, 0, 0};
    tbl[5] = '{RET_OP,  8'd0,  8'd0, 8'd0,  4'd0,  1, 1, 2, 3,  0,  2, 0, 0};
    tbl[6] = '{RET_OP,  8'd0,  8'd0, 8'd0,  4'd0,  1, 1, 2, 2,  15, 1, 0, 0};
    tbl[7] = '{RET_OP,  8'd0,  8'd0, 8'd0,  4'd0,  1, 1, 2, 1,  18, 0, 0, 0};
    tbl[8] = '{RET_OP,  8'd0,  8'd0, 8'd0,  4'd0,  1, 0, 0, 0,  0,  0, 0, 1};
    tbl[9] = '{CALL_OP, 8'd7,  8'd7, 8'd9,  4'd1,  0, 0, 0, 0,  0,  0, 0, 1};

    applyReset(1'b1);
`ifdef CALL_STACK_STATS_EN
    modelMax = 3;
`endif
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("tbl%0d", i), tbl[i]);
    end

    // Fill the frame stack, then overflow it and confirm the trap is absorbing
    applyReset(1'b1);
    for (int i = 0; i < 5; i++) begin
      v = '{CALL_OP, 8'(40 + i), 8'(60 + i), 8'd100, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0};
      modelCommand(v);
      applyStimulus(v);
      checkOutput($sformatf("ovf%0d", i), v);
    end
    v = '{RET_OP, 8'd0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 4, 6, 0};
    applyStimulus(v);
    checkOutput("ovf_hold", v);

    applyReset(1'b1);
    v = '{CALL_OP, 8'd9, 8'd8, 8'd1, 4'd2, 1, 0, 0, 0, 0, 0, 3, 0};
    applyStimulus(v);
    checkOutput("underflow", v);

    // Reset asserted while the return is in its frame-read cycle
    applyReset(1'b0);
    v = '{CALL_OP, 8'd5, 8'd2, 8'd4, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0};
    modelCommand(v);
    applyStimulus(v);
    checkOutput("pre_rd", v);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = RET_OP;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrd.ready", int'(bus.cmd_ready), 1);
    check("midrd.done", int'(bus.done), 0);
    check("midrd.next_pc", int'(bus.next_pc), 0);
    check("midrd.frame_sp", int'(bus.frame_sp), 0);
    check("midrd.depth", int'(depth), 0);
    check("midrd.halt", int'(halt), 0);
    check("midrd.trap", int'(trap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    qPc.delete();
    qSp.delete();
`ifdef CALL_STACK_STATS_EN
    modelMax = 0;
`endif

    for (int i = 0; i < 300; i++) begin
      v.op   = ($urandom_range(0, 99) < 60) ? CALL_OP : RET_OP;
      v.tgt  = 8'($urandom);
      v.rpc  = 8'($urandom);
      v.spv  = 8'($urandom_range(0, 24));
      v.args = 4'($urandom_range(0, 15));
      modelCommand(v);
      applyStimulus(v);
      checkOutput($sformatf("rnd%0d", i), v);
      if (v.expTrap != 0 || v.expHalt != 0) applyReset(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
